// File: rtl/module_spi_sequencer_if.sv
// Requester tx stream, consumer rx stream, status flags and SPI interface register bus.
// master = sequencer view, slave = application/SPI-block view.
interface module_spi_sequencer_if #(
    parameter int N = 8
);
    localparam int AW = $clog2(N);
    localparam int LW = AW + 1;

    logic          start_i;
    logic [LW-1:0] len_i;
    logic          tx_valid_i;
    logic [7:0]    tx_data_i;
    logic          tx_ready_o;
    logic          rx_valid_o;
    logic [7:0]    rx_data_o;
    logic          rx_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          wr_o;
    logic          reg_sel_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   entrada_o;
    logic [31:0]   salida_i;

    modport master (
        input  start_i, len_i, tx_valid_i, tx_data_i, rx_ready_i, salida_i,
        output tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
               wr_o, reg_sel_o, addr_o, entrada_o
    );

    modport slave (
        output start_i, len_i, tx_valid_i, tx_data_i, rx_ready_i, salida_i,
        input  tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
               wr_o, reg_sel_o, addr_o, entrada_o
    );
endinterface

// File: rtl/module_spi_sequencer.sv
// SPI register-bus sequencer: loads a tx burst, triggers send, polls, returns rx bytes.
// Latency start->done >= len+1+poll+len*(READ_LAT+1)+2 cycles; len=0 finishes the next cycle.
// Backpressure: tx_ready_o only in LOAD, rx byte held until rx_ready_i; SPI_SEQ_TIMEOUT_EN adds a poll timeout.
module module_spi_sequencer #(
    parameter int N           = 8,
    parameter int READ_LAT    = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    module_spi_sequencer_if.master bus
);
    localparam int AW = $clog2(N);
    localparam int LW = AW + 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WR_CTRL, S_POLL, S_READ, S_RX_OUT, S_RELEASE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          lat_done;
    logic          unused_salida;

    // lat_q counts cycles since addr/reg_sel settled; the last one is the valid sample
    assign lat_done      = (lat_q == CW'(READ_LAT - 1));
    assign unused_salida = ^{bus.salida_i[31:16], bus.salida_i[7:1]};

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
            rx_data_q <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        rx_data_d = rx_data_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    idx_d   = '0;
                    len_d   = (bus.len_i > LW'(N)) ? LW'(N) : bus.len_i;
                    state_d = (bus.len_i == '0) ? S_DONE : S_LOAD;
`ifdef SPI_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (bus.tx_valid_i) begin
                    if (idx_q == len_q - LW'(1)) begin
                        idx_d   = '0;
                        state_d = S_WR_CTRL;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            S_WR_CTRL: begin
                lat_d   = '0;
                state_d = S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_POLL: begin
                if (lat_done) begin
                    lat_d = '0;
                    if (!bus.salida_i[0]) begin
                        idx_d   = '0;
                        state_d = S_READ;
                    end
                end else begin
                    lat_d = lat_q + CW'(1);
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                // a completed poll in the final allowed cycle still wins over the timeout
                if (state_d == S_POLL) begin
                    if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
`endif
            end
            S_READ: begin
                if (lat_done) begin
                    lat_d     = '0;
                    rx_data_d = bus.salida_i[15:8];
                    state_d   = S_RX_OUT;
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            S_RX_OUT: begin
                if (bus.rx_ready_i) begin
                    idx_d   = idx_q + LW'(1);
                    state_d = (idx_q + LW'(1) == len_q) ? S_RELEASE : S_READ;
                end
            end
            S_RELEASE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_ready_o = 1'b0;
        bus.rx_valid_o = 1'b0;
        bus.busy_o     = (state_q != S_IDLE);
        bus.done_o     = 1'b0;
        bus.wr_o       = 1'b0;
        bus.reg_sel_o  = 1'b0;
        bus.addr_o     = '0;
        bus.entrada_o  = '0;
        unique case (state_q)
            S_LOAD: begin
                bus.tx_ready_o = 1'b1;
                if (bus.tx_valid_i) begin
                    bus.wr_o      = 1'b1;
                    bus.reg_sel_o = 1'b1;
                    bus.addr_o    = idx_q[AW-1:0];
                    bus.entrada_o = {24'h0, bus.tx_data_i};
                end
            end
            S_WR_CTRL: begin
                bus.wr_o      = 1'b1;
                bus.entrada_o = {19'h0, 9'(len_q), 2'b00, 1'b1, 1'b1};
            end
            S_READ: begin
                bus.reg_sel_o = 1'b1;
                bus.addr_o    = idx_q[AW-1:0];
            end
            S_RX_OUT: begin
                bus.reg_sel_o  = 1'b1;
                bus.addr_o     = idx_q[AW-1:0];
                bus.rx_valid_o = 1'b1;
            end
            S_RELEASE: bus.wr_o   = 1'b1;
            S_DONE:    bus.done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.rx_data_o = rx_data_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule
